is_fu_arbiter: RTL and testbench

- Issue-slot arbiter between the 2-wide reservation station and the execute stage.
- Each cycle it grants or stalls the up-to-two instructions the RS presents; its `is_stall[1:0]` feeds back into the RS.
- Enforces per-class functional-unit limits and the memory-port busy signal.
- Keeps a writeback reservation table so fixed-latency results never exceed the 2 CDB ports in any future cycle.

---
 rtl/is_fu_arbiter_if.sv | 21 ++
 rtl/is_fu_arbiter.sv | 75 +++++++
 tb/tb_is_fu_arbiter.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/is_fu_arbiter_if.sv
// is_fu_arbiter_if: issue-slot handshake between the reservation station and the FU arbiter.
// The master modport is the RS side; the slave modport is the arbiter.
interface is_fu_arbiter_if;
    logic [1:0]      req_valid;
    logic [1:0][2:0] req_fu;
    logic [1:0]      req_wb;
    logic            mem_busy;
    logic            squash;
    logic [1:0]      grant;
    logic [1:0]      is_stall;
    logic [2:0]      mult_inflight;
    logic [1:0]      rt_next;
    modport master (
        output req_valid, req_fu, req_wb, mem_busy, squash,
        input  grant, is_stall, mult_inflight, rt_next
    );
    modport slave (
        input  req_valid, req_fu, req_wb, mem_busy, squash,
        output grant, is_stall, mult_inflight, rt_next
    );
endinterface

// File: rtl/is_fu_arbiter.sv
// is_fu_arbiter: 2-wide issue arbiter enforcing FU class limits, memory-port busy and CDB writeback slots.
// A reservation table of future CDB bookings keeps fixed-latency results within the 2 CDB ports.
module is_fu_arbiter #(
    parameter int MULT_LAT = 4,
    parameter int LD_LAT   = 2,
    parameter int RT_DEPTH = 4
) (
    input logic            clock,
    input logic            reset,
    is_fu_arbiter_if.slave bus
);
    localparam int LW = $clog2(RT_DEPTH + 1);
    localparam logic [2:0] FU_MULT  = 3'd1;
    localparam logic [2:0] FU_LOAD  = 3'd2;
    localparam logic [2:0] FU_STORE = 3'd3;
    localparam logic [2:0] FU_BR    = 3'd4;
    logic [1:0]          rt_q [1:RT_DEPTH];
    logic [1:0]          rt_d [1:RT_DEPTH];
    logic [MULT_LAT-1:0] sh_q, sh_d;
    logic [2:0]          mi_q, mi_d;
    logic [1:0]          legal, ldst, books, base;
    logic [LW-1:0]       lat [2];
    logic                g0, g1, same, mg, ovf;
    logic [2:0]          sum;
    always_comb begin
        sum = 3'd0;
        ovf = 1'b0;
        for (int i = 0; i < 2; i++) begin
            legal[i] = bus.req_fu[i] <= FU_BR;
            ldst[i]  = bus.req_fu[i] == FU_LOAD || bus.req_fu[i] == FU_STORE;
            books[i] = bus.req_wb[i] && legal[i] && bus.req_fu[i] != FU_STORE;
            lat[i]   = bus.req_fu[i] == FU_MULT ? LW'(MULT_LAT) : bus.req_fu[i] == FU_LOAD ? LW'(LD_LAT) : LW'(1);
            base[i]  = bus.req_valid[i] && !bus.squash && !reset && legal[i] && !(ldst[i] && bus.mem_busy);
        end
        g0   = base[0] && (!books[0] || rt_q[lat[0]] != 2'd2);
        // slot 1 sees slot 0's grant: shared class limits and a shared CDB slot at equal latency
        same = g0 && books[0] && lat[0] == lat[1];
        g1   = base[1]
            && !(g0 && bus.req_fu[0] == bus.req_fu[1] && (bus.req_fu[1] == FU_MULT || bus.req_fu[1] == FU_BR))
            && !(g0 && ldst[0] && ldst[1])
            && (!books[1] || {1'b0, rt_q[lat[1]]} + {2'b0, same} < 3'd2);
        mg = (g0 && bus.req_fu[0] == FU_MULT) || (g1 && bus.req_fu[1] == FU_MULT);
        rt_d[RT_DEPTH] = 2'd0;
        for (int k = 1; k < RT_DEPTH; k++) begin
            sum = {1'b0, rt_q[k+1]}
                + {2'b0, g0 && books[0] && lat[0] == LW'(k + 1)}
                + {2'b0, g1 && books[1] && lat[1] == LW'(k + 1)};
            ovf = ovf | (sum > 3'd2);
            rt_d[k] = sum[1:0];
        end
        sh_d = {sh_q[MULT_LAT-2:0], mg};
        mi_d = mi_q + {2'b0, mg} - {2'b0, sh_q[MULT_LAT-1]};
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 1; k <= RT_DEPTH; k++) rt_q[k] <= 2'd0;
            sh_q <= '0;
            mi_q <= 3'd0;
        end else if (bus.squash) begin
            for (int k = 1; k <= RT_DEPTH; k++) rt_q[k] <= 2'd0;
            sh_q <= '0;
            mi_q <= 3'd0;
        end else begin
            for (int k = 1; k <= RT_DEPTH; k++) rt_q[k] <= rt_d[k];
            sh_q <= sh_d;
            mi_q <= mi_d;
        end
    end
    assign bus.grant         = {g1, g0};
    assign bus.is_stall      = bus.req_valid & ~{g1, g0};
    assign bus.mult_inflight = mi_q;
    assign bus.rt_next       = rt_q[1];
    a_no_overflow: assert property (@(posedge clock) disable iff (reset) !ovf);
    a_legal_class: assert property (@(posedge clock) disable iff (reset) !(|(bus.req_valid & ~legal)));
endmodule

// File: tb/tb_is_fu_arbiter.sv
// tb_is_fu_arbiter: directed vectors from an empty table plus multi-cycle sequences for the
// reservation table, MULT pipe tracking, squash and asynchronous reset.
module tb_is_fu_arbiter;
    localparam logic [2:0] ALU = 3'd0, MUL = 3'd1, LD = 3'd2, ST = 3'd3, BR = 3'd4;
    typedef struct {
        logic [1:0] v;
        logic [2:0] f0;
        logic [2:0] f1;
        logic [1:0] wb;
        logic       mb;
        logic       sq;
        logic [1:0] g;
        logic [1:0] st;
        logic [1:0] rt;
        logic [2:0] mi;
    } vec_t;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   failures = 0;
    vec_t tv [14];
    is_fu_arbiter_if bus();
    is_fu_arbiter dut (.clock(clock), .reset(reset), .bus(bus));
    always #5 clock = ~clock;
    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic drv(input logic [1:0] v, input logic [2:0] f0, input logic [2:0] f1,
                       input logic [1:0] wb, input logic mb, input logic sq);
        bus.req_valid = v;
        bus.req_fu[0] = f0;
        bus.req_fu[1] = f1;
        bus.req_wb    = wb;
        bus.mem_busy  = mb;
        bus.squash    = sq;
        #1;
    endtask
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    task automatic idle();
        drv(2'b00, ALU, ALU, 2'b00, 1'b0, 1'b0);
    endtask
    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask
    initial begin
        tv[0]  = '{2'b11, ALU, ALU, 2'b11, 1'b0, 1'b0, 2'b11, 2'b00, 2'd0, 3'd0};
        tv[1]  = '{2'b11, MUL, MUL, 2'b11, 1'b0, 1'b0, 2'b01, 2'b10, 2'd0, 3'd1};
        tv[2]  = '{2'b11, ST,  ALU, 2'b10, 1'b1, 1'b0, 2'b10, 2'b01, 2'd0, 3'd0};
        tv[3]  = '{2'b11, LD,  LD,  2'b11, 1'b0, 1'b0, 2'b01, 2'b10, 2'd1, 3'd0};
        tv[4]  = '{2'b11, LD,  ST,  2'b01, 1'b0, 1'b0, 2'b01, 2'b10, 2'd1, 3'd0};
        tv[5]  = '{2'b11, BR,  BR,  2'b00, 1'b0, 1'b0, 2'b01, 2'b10, 2'd0, 3'd0};
        tv[6]  = '{2'b11, ALU, BR,  2'b11, 1'b0, 1'b0, 2'b11, 2'b00, 2'd0, 3'd0};
        tv[7]  = '{2'b11, ALU, ALU, 2'b11, 1'b0, 1'b1, 2'b00, 2'b11, 2'd0, 3'd0};
        tv[8]  = '{2'b10, ALU, MUL, 2'b10, 1'b0, 1'b0, 2'b10, 2'b00, 2'd0, 3'd1};
        tv[9]  = '{2'b00, MUL, LD,  2'b11, 1'b0, 1'b0, 2'b00, 2'b00, 2'd0, 3'd0};
        tv[10] = '{2'b11, MUL, LD,  2'b11, 1'b0, 1'b0, 2'b11, 2'b00, 2'd1, 3'd1};
        tv[11] = '{2'b11, ST,  LD,  2'b10, 1'b0, 1'b0, 2'b01, 2'b10, 2'd0, 3'd0};
        tv[12] = '{2'b11, LD,  MUL, 2'b11, 1'b1, 1'b0, 2'b10, 2'b01, 2'd0, 3'd1};
        tv[13] = '{2'b01, ALU, ALU, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00, 2'd0, 3'd0};
        idle();
        reset = 1'b1;
        #2;
        chk("reset_grant", {2'b0, bus.grant}, 4'd0);
        chk("reset_rt_next", {2'b0, bus.rt_next}, 4'd0);
        chk("reset_mi", {1'b0, bus.mult_inflight}, 4'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 14; i++) begin
            do_reset();
            drv(tv[i].v, tv[i].f0, tv[i].f1, tv[i].wb, tv[i].mb, tv[i].sq);
            chk($sformatf("vec%0d_grant", i), {2'b0, bus.grant}, {2'b0, tv[i].g});
            chk($sformatf("vec%0d_stall", i), {2'b0, bus.is_stall}, {2'b0, tv[i].st});
            tick();
            chk($sformatf("vec%0d_rt_next", i), {2'b0, bus.rt_next}, {2'b0, tv[i].rt});
            chk($sformatf("vec%0d_mi", i), {1'b0, bus.mult_inflight}, {1'b0, tv[i].mi});
        end
        // reset mid-cycle while a MULT booking sits at R[2]
        do_reset();
        drv(2'b01, MUL, ALU, 2'b01, 1'b0, 1'b0);
        chk("rst_mul_grant", {2'b0, bus.grant}, 4'd1);
        tick();
        idle();
        tick();
        chk("rst_pre_mi", {1'b0, bus.mult_inflight}, 4'd1);
        drv(2'b11, ALU, ALU, 2'b11, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk("rst_async_mi", {1'b0, bus.mult_inflight}, 4'd0);
        chk("rst_async_grant", {2'b0, bus.grant}, 4'd0);
        chk("rst_async_stall", {2'b0, bus.is_stall}, 4'd3);
        tick();
        reset = 1'b0;
        #1;
        chk("rst_post_rt_next", {2'b0, bus.rt_next}, 4'd0);
        chk("rst_post_grant", {2'b0, bus.grant}, 4'd3);
        // two MULTs back to back: one per cycle
        do_reset();
        drv(2'b11, MUL, MUL, 2'b11, 1'b0, 1'b0);
        chk("mm_grant", {2'b0, bus.grant}, 4'd1);
        chk("mm_stall", {2'b0, bus.is_stall}, 4'd2);
        tick();
        drv(2'b01, MUL, ALU, 2'b01, 1'b0, 1'b0);
        chk("mm2_grant", {2'b0, bus.grant}, 4'd1);
        tick();
        chk("mm2_mi", {1'b0, bus.mult_inflight}, 4'd2);
        // MULT writeback lands at t+4, blocking one ALU CDB slot at t+3
        do_reset();
        drv(2'b01, MUL, ALU, 2'b01, 1'b0, 1'b0);
        tick();
        idle();
        tick();
        tick();
        chk("mt3_rt_next", {2'b0, bus.rt_next}, 4'd1);
        drv(2'b11, ALU, ALU, 2'b11, 1'b0, 1'b0);
        chk("mt3_alu_wb_grant", {2'b0, bus.grant}, 4'd1);
        drv(2'b11, ALU, ALU, 2'b00, 1'b0, 1'b0);
        chk("mt3_alu_nowb_grant", {2'b0, bus.grant}, 4'd3);
        idle();
        tick();
        chk("mt4_mi", {1'b0, bus.mult_inflight}, 4'd1);
        tick();
        chk("mt5_mi", {1'b0, bus.mult_inflight}, 4'd0);
        // LOAD sharing a CDB slot with an earlier MULT, then a full slot
        do_reset();
        drv(2'b01, MUL, ALU, 2'b01, 1'b0, 1'b0);
        tick();
        drv(2'b01, MUL, ALU, 2'b01, 1'b0, 1'b0);
        tick();
        drv(2'b11, LD, LD, 2'b11, 1'b0, 1'b0);
        chk("ld_grant", {2'b0, bus.grant}, 4'd1);
        chk("ld_stall", {2'b0, bus.is_stall}, 4'd2);
        tick();
        chk("ld_rt_next", {2'b0, bus.rt_next}, 4'd2);
        drv(2'b11, ALU, ALU, 2'b11, 1'b0, 1'b0);
        chk("full_alu_wb_grant", {2'b0, bus.grant}, 4'd0);
        drv(2'b11, ALU, ALU, 2'b00, 1'b0, 1'b0);
        chk("full_alu_nowb_grant", {2'b0, bus.grant}, 4'd3);
        // squash with a populated table and three MULTs in flight
        do_reset();
        drv(2'b01, MUL, ALU, 2'b01, 1'b0, 1'b0);
        tick();
        drv(2'b01, MUL, ALU, 2'b01, 1'b0, 1'b0);
        tick();
        drv(2'b11, MUL, LD, 2'b11, 1'b0, 1'b0);
        chk("sq_pre_grant", {2'b0, bus.grant}, 4'd3);
        tick();
        chk("sq_pre_rt_next", {2'b0, bus.rt_next}, 4'd2);
        chk("sq_pre_mi", {1'b0, bus.mult_inflight}, 4'd3);
        drv(2'b11, ALU, ALU, 2'b11, 1'b0, 1'b1);
        chk("sq_grant", {2'b0, bus.grant}, 4'd0);
        chk("sq_stall", {2'b0, bus.is_stall}, 4'd3);
        tick();
        drv(2'b11, ALU, ALU, 2'b11, 1'b0, 1'b0);
        chk("sq_post_rt_next", {2'b0, bus.rt_next}, 4'd0);
        chk("sq_post_mi", {1'b0, bus.mult_inflight}, 4'd0);
        chk("sq_post_grant", {2'b0, bus.grant}, 4'd3);
        tick();
        chk("sq_post2_rt_next", {2'b0, bus.rt_next}, 4'd0);
        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
